// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: elastic N-slot pipe register chain with flush, backpressure,
// bubble collapsing and decode-stage forwarding/load-use hazard lookup.
module pipe_reg_chain #(
    parameter int DATA_W     = 32,
    parameter int STAGES     = 3,
    parameter int DEST_W     = 5,
    parameter int LATE_STAGE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              in_wr,
    input  logic              in_late,
    input  logic [STAGES-1:0] flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DEST_W-1:0] out_dest,
    output logic              out_wr,
    input  logic [DEST_W-1:0] src_a,
    input  logic [DEST_W-1:0] src_b,
    output logic              fwd_a_hit,
    output logic              fwd_b_hit,
    output logic [DATA_W-1:0] fwd_a_data,
    output logic [DATA_W-1:0] fwd_b_data,
    output logic              stall_req
);
    logic [STAGES-1:0] v, wr, late, move;
    logic [DATA_W-1:0] data [STAGES];
    logic [DEST_W-1:0] dest [STAGES];
    logic blk, stall_a, stall_b;

    // blk tracks "everything from slot i+1 to the output is full and stuck"
    always_comb begin
        move = '0;
        blk = v[STAGES-1] & ~out_ready;
        move[STAGES-1] = ~blk;
        for (int i = STAGES-2; i >= 0; i--) begin
            blk = blk & v[i+1];
            move[i] = ~blk;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v    <= '0;
            wr   <= '0;
            late <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data[i] <= '0;
                dest[i] <= '0;
            end
        end else begin
            v[0] <= (move[0] ? in_valid : v[0]) & ~flush[0];
            if (move[0]) begin
                data[0] <= in_data;
                dest[0] <= in_dest;
                wr[0]   <= in_wr;
                late[0] <= in_late;
            end
            for (int i = 1; i < STAGES; i++) begin
                v[i] <= (move[i] ? v[i-1] : v[i]) & ~flush[i];
                if (move[i]) begin
                    data[i] <= data[i-1];
                    dest[i] <= dest[i-1];
                    wr[i]   <= wr[i-1];
                    late[i] <= late[i-1];
                end
            end
        end
    end

    // result = {hit, stall, data}; scanning oldest to youngest lets the youngest win
    function automatic logic [DATA_W+1:0] lookup(input logic [DEST_W-1:0] s);
        logic [DATA_W+1:0] r;
        r = '0;
        for (int i = STAGES-1; i >= 0; i--)
            if (v[i] && wr[i] && dest[i] == s && s != '0)
                r = (late[i] && i < LATE_STAGE) ? {2'b01, {DATA_W{1'b0}}} : {2'b10, data[i]};
        return r;
    endfunction

    assign {fwd_a_hit, stall_a, fwd_a_data} = lookup(src_a);
    assign {fwd_b_hit, stall_b, fwd_b_data} = lookup(src_b);
    assign stall_req = stall_a | stall_b;
    assign in_ready  = move[0];
    assign out_valid = v[STAGES-1];
    assign out_data  = data[STAGES-1];
    assign out_dest  = dest[STAGES-1];
    assign out_wr    = v[STAGES-1] & wr[STAGES-1];
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: scoreboard bench for a 3-slot pipe_reg_chain (LATE_STAGE=1).
module tb_pipe_reg_chain;
    logic        clk = 0, reset = 0;
    logic        in_valid = 0, in_ready, in_wr = 0, in_late = 0;
    logic [31:0] in_data = 0, out_data, fwd_a_data, fwd_b_data;
    logic [4:0]  in_dest = 0, out_dest, src_a = 0, src_b = 0;
    logic [2:0]  flush = 0;
    logic        out_valid, out_ready = 1, out_wr, fwd_a_hit, fwd_b_hit, stall_req;

    typedef struct packed {logic [31:0] d; logic [4:0] r; logic w;} ent_t;
    ent_t exp_q[$];
    ent_t mon_e;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    pipe_reg_chain #(.DATA_W(32), .STAGES(3), .DEST_W(5), .LATE_STAGE(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dest(in_dest), .in_wr(in_wr), .in_late(in_late),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_dest(out_dest), .out_wr(out_wr),
        .src_a(src_a), .src_b(src_b), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
        .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data), .stall_req(stall_req)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: an output handshake seen mid-cycle completes on the next rising edge
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got %0h expected nothing", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_data", out_data, mon_e.d);
                check("sb_dest", 32'(out_dest), 32'(mon_e.r));
                check("sb_wr", 32'(out_wr), 32'(mon_e.w));
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [4:0] r, input logic w, input logic l);
        logic acc;
        acc = 0;
        in_valid = 1; in_data = d; in_dest = r; in_wr = w; in_late = l;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) exp_q.push_back('{d: d, r: r, w: w});
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        check("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        out_ready = 1;
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
        check("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        src_a = 5'd3; src_b = 5'd4;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_wr", 32'(out_wr), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_stall", 32'(stall_req), 0);
        check("rst_fwd_a", {31'b0, fwd_a_hit} | fwd_a_data, 0);
        check("rst_fwd_b", {31'b0, fwd_b_hit} | fwd_b_data, 0);
        reset = 1;
        @(posedge clk);
        #1;

        // Fill: accepts at edges 0..2, outputs visible after edges 2..4
        for (int c = 0; c < 7; c++) begin
            in_valid = c < 3; in_data = 32'h11 * (c + 1); in_dest = 5'(c + 1); in_wr = 1;
            @(negedge clk);
            check("fill_in_ready", 32'(in_ready), 1);
            if (c < 3) exp_q.push_back('{d: in_data, r: in_dest, w: 1'b1});
            @(posedge clk);
            #1;
            check("fill_out_valid", 32'(out_valid), 32'(c >= 2 && c <= 4));
            if (c >= 2 && c <= 4) check("fill_out_data", out_data, 32'h11 * (c - 1));
        end
        in_valid = 0;

        // Backpressure
        out_ready = 0;
        send(32'h100, 5'd1, 1, 0);
        send(32'h200, 5'd2, 0, 0);
        send(32'h300, 5'd3, 1, 0);
        for (int c = 0; c < 4; c++) begin
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_hold_data", out_data, 32'h100);
            @(posedge clk);
            #1;
        end
        drain();

        // Flush middle slot while the chain is stalled
        out_ready = 0;
        send(32'hC, 5'd12, 1, 0);
        send(32'hB, 5'd11, 1, 0);
        send(32'hA, 5'd10, 1, 0);
        exp_q.delete(1);
        flush = 3'b010;
        @(posedge clk);
        #1;
        flush = 0;
        check("flush_head", out_data, 32'hC);
        drain();

        // Forwarding priority
        out_ready = 0;
        send(32'h1234, 5'd0, 1, 0);
        send(32'hBBBB, 5'd5, 1, 0);
        send(32'hAAAA, 5'd5, 1, 0);
        src_a = 5'd5; src_b = 5'd0;
        #1;
        check("fwd_a_hit", 32'(fwd_a_hit), 1);
        check("fwd_a_young", fwd_a_data, 32'hAAAA);
        check("fwd_b_zero_hit", 32'(fwd_b_hit), 0);
        check("fwd_b_zero_data", fwd_b_data, 0);
        check("fwd_nostall", 32'(stall_req), 0);
        src_b = 5'd3;
        #1;
        check("fwd_b_miss", {31'b0, fwd_b_hit} | fwd_b_data, 0);
        drain();

        // Load-use hazard
        out_ready = 0; src_a = 5'd7; src_b = 5'd0;
        send(32'h7777, 5'd7, 1, 1);
        check("lu_stall", 32'(stall_req), 1);
        check("lu_no_hit", 32'(fwd_a_hit), 0);
        @(posedge clk);
        #1;
        check("lu_stall_clr", 32'(stall_req), 0);
        check("lu_hit", 32'(fwd_a_hit), 1);
        check("lu_data", fwd_a_data, 32'h7777);
        send(32'h8888, 5'd7, 1, 1);
        check("lu_stall2", 32'(stall_req), 1);
        check("pre_rst_valid", 32'(out_valid), 1);

        // Async reset between edges
        #2 reset = 0;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_stall", 32'(stall_req), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        check("arst_out_data", out_data, 0);
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1;
        out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_valid", 32'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
